// File: rtl/instr_loader.sv
// Byte-stream instruction loader: assembles big-endian 24-bit words, writes them
// into instruction memory and releases the CPU only after a matching XOR checksum.
module instr_loader #(
  parameter logic [23:0] BASE_ADDR = 24'd10,
  parameter logic [23:0] ADDR_STEP = 24'd3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [23:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  // Handshake: a byte moves on a rising edge only when byte_valid and byte_ready
  // are both 1; byte_ready depends on state alone, never on byte_valid.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [7:0]  word_idx;
  logic [7:0]  count;
  logic [7:0]  csum;
  logic [15:0] word_buf;
  logic [23:0] addr_acc;
  logic [7:0]  word_idx_nxt;

  assign word_idx_nxt = word_idx + 8'd1;
  assign byte_ready   = (state == LOAD) || (state == CHECK);
  // Hold rises in the same cycle a restart is requested from DONE.
  assign cpu_hold     = (state != DONE) || start;
  assign dbg_state    = state;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      byte_idx  <= 2'd0;
      word_idx  <= 8'd0;
      count     <= 8'd0;
      csum      <= 8'd0;
      word_buf  <= 16'd0;
      addr_acc  <= BASE_ADDR;
      mem_we    <= 1'b0;
      mem_addr  <= 24'd0;
      mem_wdata <= 24'd0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            count    <= word_count;
            byte_idx <= 2'd0;
            word_idx <= 8'd0;
            csum     <= 8'd0;
            addr_acc <= BASE_ADDR;
            done     <= 1'b0;
            err      <= 1'b0;
            state    <= (word_count != 8'd0) ? LOAD : CHECK;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            csum <= csum ^ byte_data;
            case (byte_idx)
              2'd0: begin
                word_buf[15:8] <= byte_data;
                byte_idx       <= 2'd1;
              end
              2'd1: begin
                word_buf[7:0] <= byte_data;
                byte_idx      <= 2'd2;
              end
              default: begin
                mem_wdata <= {word_buf, byte_data};
                mem_addr  <= addr_acc;
                mem_we    <= 1'b1;
                byte_idx  <= 2'd0;
                state     <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          mem_we   <= 1'b0;
          word_idx <= word_idx_nxt;
          addr_acc <= addr_acc + ADDR_STEP;
          state    <= (word_idx_nxt == count) ? CHECK : LOAD;
        end
        CHECK: begin
          if (byte_valid) begin
            if (byte_data == csum) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b1;
              state <= ERR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
